// File: rtl/dbrk_arb_if.sv
// Bus bundle between the data-break arbiter, its two DMA requesters and the CPU break path.
// The slave modport is the arbiter's view; master is the requester/CPU side.
interface dbrk_arb_if;
    logic        req0;
    logic        wr0;
    logic [14:0] addr0;
    logic [11:0] wdata0;
    logic        gnt0;
    logic        req1;
    logic        wr1;
    logic [14:0] addr1;
    logic [11:0] wdata1;
    logic        gnt1;
    logic [11:0] rdata;
    logic        data_break;
    logic        break_wr;
    logic [14:0] break_addr;
    logic [11:0] break_data;
    logic        break_in_prog;
    logic [11:0] mem_rdata;
    logic        timeout_err;

    modport slave (
        input  req0, wr0, addr0, wdata0,
        input  req1, wr1, addr1, wdata1,
        input  break_in_prog, mem_rdata,
        output gnt0, gnt1, rdata,
        output data_break, break_wr, break_addr, break_data,
        output timeout_err
    );

    modport master (
        output req0, wr0, addr0, wdata0,
        output req1, wr1, addr1, wdata1,
        output break_in_prog, mem_rdata,
        input  gnt0, gnt1, rdata,
        input  data_break, break_wr, break_addr, break_data,
        input  timeout_err
    );
endinterface

// File: rtl/dbrk_arb.sv
// PDP-8 data-break arbiter: two DMA ports share one CPU memory-break path, with a break watchdog.
// Define DBRK_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dbrk_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    dbrk_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BRK  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [11:0] TIMEOUT_C = 12'(TIMEOUT);

    state_t      state_r;
    logic [11:0] cnt_r;
    logic [11:0] cnt_inc_s;
    logic        win_r;
    logic [11:0] samp_r;
    logic        data_break_r;
    logic        break_wr_r;
    logic [14:0] break_addr_r;
    logic [11:0] break_data_r;
    logic        gnt0_r;
    logic        gnt1_r;
    logic [11:0] rdata_r;
    logic        timeout_err_r;
    logic        any_req_s;
    logic        pick_s;
    logic        start_s;
    logic        sel_wr_s;
    logic [14:0] sel_addr_s;
    logic [11:0] sel_data_s;

`ifdef DBRK_RR_EN
    logic        last_r;

    // Last-winner memory; resets to port 1 so port 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            last_r <= 1'b1;
        end else if (start_s) begin
            last_r <= pick_s;
        end else begin
            last_r <= last_r;
        end
    end

    // Round-robin winner: on a tie, the port that lost last time goes.
    always_comb begin
        pick_s = 1'b0;
        if (bus.req0 && bus.req1) begin
            pick_s = ~last_r;
        end else if (bus.req1) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end
`else
    // Fixed-priority winner: port 0 always beats port 1.
    always_comb begin
        pick_s = 1'b0;
        if (bus.req0) begin
            pick_s = 1'b0;
        end else if (bus.req1) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end
`endif

    // Start decode and capture mux; a stale break_in_prog blocks arbitration.
    always_comb begin
        any_req_s  = bus.req0 | bus.req1;
        cnt_inc_s  = cnt_r + 12'd1;
        start_s    = 1'b0;
        if ((state_r == IDLE) && !bus.break_in_prog && any_req_s) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
        if (pick_s) begin
            sel_wr_s   = bus.wr1;
            sel_addr_s = bus.addr1;
            sel_data_s = bus.wdata1;
        end else begin
            sel_wr_s   = bus.wr0;
            sel_addr_s = bus.addr0;
            sel_data_s = bus.wdata0;
        end
    end

    // Break sequencer with registered outputs; gnt is a single DONE-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_r       <= IDLE;
            cnt_r         <= 12'd0;
            win_r         <= 1'b0;
            samp_r        <= 12'd0;
            data_break_r  <= 1'b0;
            break_wr_r    <= 1'b0;
            break_addr_r  <= 15'd0;
            break_data_r  <= 12'd0;
            gnt0_r        <= 1'b0;
            gnt1_r        <= 1'b0;
            rdata_r       <= 12'd0;
            timeout_err_r <= 1'b0;
        end else begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        break_wr_r   <= sel_wr_s;
                        break_addr_r <= sel_addr_s;
                        break_data_r <= sel_data_s;
                        win_r        <= pick_s;
                        data_break_r <= 1'b1;
                        cnt_r        <= 12'd0;
                        state_r      <= REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (bus.break_in_prog) begin
                        data_break_r <= 1'b0;
                        samp_r       <= bus.mem_rdata;
                        state_r      <= BRK;
                    end else if (cnt_inc_s == TIMEOUT_C) begin
                        // Abandon the break but still complete the handshake; rdata is left alone.
                        cnt_r         <= cnt_inc_s;
                        data_break_r  <= 1'b0;
                        timeout_err_r <= 1'b1;
                        gnt0_r        <= ~win_r;
                        gnt1_r        <= win_r;
                        state_r       <= DONE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                BRK: begin
                    if (bus.break_in_prog) begin
                        samp_r <= bus.mem_rdata;
                    end else begin
                        gnt0_r  <= ~win_r;
                        gnt1_r  <= win_r;
                        if (!break_wr_r) begin
                            rdata_r <= samp_r;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    data_break_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0        = gnt0_r;
    assign bus.gnt1        = gnt1_r;
    assign bus.rdata       = rdata_r;
    assign bus.data_break  = data_break_r;
    assign bus.break_wr    = break_wr_r;
    assign bus.break_addr  = break_addr_r;
    assign bus.break_data  = break_data_r;
    assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_dbrk_arb.sv
// Directed bench for dbrk_arb: read, write, arbitration order, watchdog timeout and reset mid-break.
module tb_dbrk_arb;
    logic clk;
    logic reset;
    logic clear;
    int   compared;
    int   mismatched;
    int   gnt0_cnt;
    int   gnt1_cnt;
    int   both_cnt;
    logic [11:0] exp_rdata;

    dbrk_arb_if bus ();

    dbrk_arb #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent observer of grant pulses
    always @(negedge clk) begin
        if (bus.gnt0 === 1'b1) gnt0_cnt++;
        if (bus.gnt1 === 1'b1) gnt1_cnt++;
        if (bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1) both_cnt++;
    end

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.addr0 = 15'd0; bus.wdata0 = 12'd0;
        bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.addr1 = 15'd0; bus.wdata1 = 12'd0;
        bus.break_in_prog = 1'b0;
        bus.mem_rdata = 12'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // CPU side: wait for data_break, run a one-cycle break, return the port that got gnt
    task automatic serve(input logic [11:0] mem, output int port);
        int n;
        port = -1;
        n = 0;
        while (bus.data_break !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (bus.data_break !== 1'b1) begin
            mismatched++;
            $display("FAIL serve_wait_break: data_break=%b required 1 within 20 cycles", bus.data_break);
        end
        bus.break_in_prog = 1'b1;
        bus.mem_rdata = mem;
        @(negedge clk);
        bus.break_in_prog = 1'b0;
        bus.mem_rdata = 12'd0;
        n = 0;
        while (bus.gnt0 !== 1'b1 && bus.gnt1 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.gnt0 === 1'b1) port = 0;
        else if (bus.gnt1 === 1'b1) port = 1;
        else port = -1;
    endtask

    task automatic test_reset();
        idle_inputs();
        clear = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if ({bus.data_break, bus.break_wr, bus.gnt0, bus.gnt1, bus.timeout_err} !== 5'b00000) begin
            mismatched++;
            $display("FAIL reset_flags: db/wr/g0/g1/to=%b required 00000",
                     {bus.data_break, bus.break_wr, bus.gnt0, bus.gnt1, bus.timeout_err});
        end
        compared++;
        if (bus.break_addr !== 15'd0 || bus.break_data !== 12'd0 || bus.rdata !== 12'd0) begin
            mismatched++;
            $display("FAIL reset_data: addr=%o data=%o rdata=%o required 0/0/0",
                     bus.break_addr, bus.break_data, bus.rdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int g1;
        g1 = gnt1_cnt;
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 15'o12345;
        @(negedge clk);
        compared++;
        if (bus.data_break !== 1'b1 || bus.break_addr !== 15'o12345 || bus.break_wr !== 1'b0) begin
            mismatched++;
            $display("FAIL read_issue: db=%b addr=%o wr=%b required 1/12345/0",
                     bus.data_break, bus.break_addr, bus.break_wr);
        end
        bus.break_in_prog = 1'b1;
        bus.mem_rdata = 12'o7070;
        @(negedge clk);
        compared++;
        if (bus.data_break !== 1'b0) begin
            mismatched++;
            $display("FAIL read_db_in_brk: data_break=%b required 0", bus.data_break);
        end
        @(negedge clk);
        bus.break_in_prog = 1'b0;
        bus.mem_rdata = 12'o1111;
        @(negedge clk);
        compared++;
        if (bus.gnt0 !== 1'b1 || bus.rdata !== 12'o7070) begin
            mismatched++;
            $display("FAIL read_done: gnt0=%b rdata=%o required 1/7070", bus.gnt0, bus.rdata);
        end
        bus.req0 = 1'b0;
        exp_rdata = 12'o7070;
        @(negedge clk);
        compared++;
        if (bus.gnt0 !== 1'b0 || bus.data_break !== 1'b0) begin
            mismatched++;
            $display("FAIL read_pulse_len: gnt0=%b db=%b required 0/0", bus.gnt0, bus.data_break);
        end
        @(negedge clk);
        compared++;
        if (gnt1_cnt !== g1) begin
            mismatched++;
            $display("FAIL read_no_gnt1: gnt1 pulses=%0d required %0d", gnt1_cnt, g1);
        end
    endtask

    task automatic test_single_write();
        bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.addr1 = 15'o00200; bus.wdata1 = 12'o1234;
        @(negedge clk);
        compared++;
        if (bus.data_break !== 1'b1 || bus.break_wr !== 1'b1 || bus.break_addr !== 15'o00200 ||
            bus.break_data !== 12'o1234) begin
            mismatched++;
            $display("FAIL write_issue: db=%b wr=%b addr=%o data=%o required 1/1/200/1234",
                     bus.data_break, bus.break_wr, bus.break_addr, bus.break_data);
        end
        bus.break_in_prog = 1'b1;
        bus.mem_rdata = 12'o5555;
        @(negedge clk);
        bus.break_in_prog = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0 || bus.rdata !== exp_rdata) begin
            mismatched++;
            $display("FAIL write_done: gnt1=%b gnt0=%b rdata=%o required 1/0/%o",
                     bus.gnt1, bus.gnt0, bus.rdata, exp_rdata);
        end
        bus.req1 = 1'b0; bus.wr1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int p;
        int order [4];
        int exp_order [4];
        // Each requester drops after its own grant: port 0 first under either policy
        bus.req0 = 1'b1; bus.addr0 = 15'o00010;
        bus.req1 = 1'b1; bus.addr1 = 15'o00020;
        serve(12'o4321, p);
        compared++;
        if (p !== 0) begin
            mismatched++;
            $display("FAIL tie_first: granted port %0d required 0", p);
        end
        bus.req0 = 1'b0;
        serve(12'o4321, p);
        compared++;
        if (p !== 1) begin
            mismatched++;
            $display("FAIL tie_second: granted port %0d required 1", p);
        end
        bus.req1 = 1'b0;
        exp_rdata = 12'o4321;
        compared++;
        if (bus.rdata !== exp_rdata) begin
            mismatched++;
            $display("FAIL tie_rdata: rdata=%o required %o", bus.rdata, exp_rdata);
        end
        do_reset();
        exp_rdata = 12'd0;
        // Continuous requests on both ports
`ifdef DBRK_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            serve(12'o0707, p);
            order[k] = p;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        exp_rdata = 12'o0707;
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (order[k] !== exp_order[k]) begin
                mismatched++;
                $display("FAIL continuous_order[%0d]: granted port %0d required %0d", k, order[k], exp_order[k]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        int db_cycles;
        int n;
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 15'o00400;
        bus.break_in_prog = 1'b0;
        @(negedge clk);
        db_cycles = 0;
        n = 0;
        while (bus.data_break === 1'b1 && n < 40) begin
            db_cycles++;
            n++;
            @(negedge clk);
        end
        compared++;
        if (db_cycles !== 8) begin
            mismatched++;
            $display("FAIL timeout_len: data_break high %0d cycles required 8", db_cycles);
        end
        compared++;
        if (bus.gnt0 !== 1'b1 || bus.timeout_err !== 1'b1 || bus.rdata !== exp_rdata) begin
            mismatched++;
            $display("FAIL timeout_done: gnt0=%b timeout_err=%b rdata=%o required 1/1/%o",
                     bus.gnt0, bus.timeout_err, bus.rdata, exp_rdata);
        end
        bus.req0 = 1'b0;
        repeat (4) @(negedge clk);
        compared++;
        if (bus.timeout_err !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_sticky: timeout_err=%b required 1", bus.timeout_err);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        compared++;
        if (bus.timeout_err !== 1'b0 || bus.rdata !== 12'd0) begin
            mismatched++;
            $display("FAIL timeout_clear: timeout_err=%b rdata=%o required 0/0", bus.timeout_err, bus.rdata);
        end
        exp_rdata = 12'd0;
    endtask

    task automatic test_reset_mid_brk();
        int g0;
        int p;
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 15'o07000;
        @(negedge clk);
        bus.break_in_prog = 1'b1;
        bus.mem_rdata = 12'o6666;
        @(negedge clk);
        g0 = gnt0_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compared++;
        if (bus.data_break !== 1'b0 || bus.gnt0 !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_brk: db=%b gnt0=%b required 0/0", bus.data_break, bus.gnt0);
        end
        // Stale break cycle still running: arbitration must hold off
        repeat (3) @(negedge clk);
        compared++;
        if (bus.data_break !== 1'b0 || gnt0_cnt !== g0) begin
            mismatched++;
            $display("FAIL rst_stale_bip: db=%b gnt0 pulses=%0d required 0/%0d", bus.data_break, gnt0_cnt, g0);
        end
        bus.break_in_prog = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.data_break !== 1'b1 || bus.break_addr !== 15'o07000) begin
            mismatched++;
            $display("FAIL rst_reissue: db=%b addr=%o required 1/7000", bus.data_break, bus.break_addr);
        end
        serve(12'o2525, p);
        compared++;
        if (p !== 0 || bus.rdata !== 12'o2525) begin
            mismatched++;
            $display("FAIL rst_complete: port=%0d rdata=%o required 0/2525", p, bus.rdata);
        end
        bus.req0 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_exclusive();
        compared++;
        if (both_cnt !== 0) begin
            mismatched++;
            $display("FAIL gnt_exclusive: both-high cycles=%0d required 0", both_cnt);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        gnt0_cnt   = 0;
        gnt1_cnt   = 0;
        both_cnt   = 0;
        exp_rdata  = 12'd0;
        reset      = 1'b1;
        clear      = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_single_write();
        test_simultaneous();
        test_timeout();
        test_reset_mid_brk();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
